// File: rtl/rf_alu_sequencer_if.sv
// Command and register-file bus of rf_alu_sequencer; slave is the sequencer, master the command source plus register file.
interface rf_alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;
    logic              rf_mode;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_value;
    logic [ADDR_W-1:0] rf_read_addr1;
    logic [ADDR_W-1:0] rf_read_addr2;
    logic [DATA_W-1:0] rf_read_value1;
    logic [DATA_W-1:0] rf_read_value2;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  rf_read_value1, rf_read_value2,
        output cmd_ready, rf_mode, rf_write_addr, rf_write_value,
        output rf_read_addr1, rf_read_addr2, result, carry, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output rf_read_value1, rf_read_value2,
        input  cmd_ready, rf_mode, rf_write_addr, rf_write_value,
        input  rf_read_addr1, rf_read_addr2, result, carry, busy, done
    );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Sequences one register-file ADD/SUB/MOV/LDI command: read, execute, write setup, write commit (RFSEQ_ZERO_REG_EN hardwires r0 to 0).
// Latency: accept edge N, rf_mode pulse in the 4th cycle after it, done in the 5th; one command per 5 cycles.
// Backpressure: cmd_ready high only in IDLE; command inputs are latched at accept and need not be held.
module rf_alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_alu_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXEC, S_WSETUP, S_WCOMMIT
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MOV = 2'd2;
    localparam logic [1:0] OP_LDI = 2'd3;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_rf_mode;
    logic [ADDR_W-1:0] r_rf_write_addr;
    logic [DATA_W-1:0] r_rf_write_value;
    logic [ADDR_W-1:0] r_rf_read_addr1;
    logic [ADDR_W-1:0] r_rf_read_addr2;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;

    logic [DATA_W-1:0] w_rd_val1;
    logic [DATA_W-1:0] w_rd_val2;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_cy;

`ifdef RFSEQ_ZERO_REG_EN
    assign w_rd_val1 = (r_rf_read_addr1 == '0) ? '0 : bus.rf_read_value1;
    assign w_rd_val2 = (r_rf_read_addr2 == '0) ? '0 : bus.rf_read_value2;
    assign w_wr_en   = (r_rd != '0);
`else
    assign w_rd_val1 = bus.rf_read_value1;
    assign w_rd_val2 = bus.rf_read_value2;
    assign w_wr_en   = 1'b1;
`endif

    // SUB is a + ~b + 1, so the carry out doubles as the no-borrow flag.
    assign w_addend = (r_op == OP_SUB) ? ~r_op_b : r_op_b;
    assign w_sum    = {1'b0, r_op_a} + {1'b0, w_addend} + {{DATA_W{1'b0}}, (r_op == OP_SUB)};

    always_comb begin
        w_res = w_sum[DATA_W-1:0];
        w_cy  = w_sum[DATA_W];
        case (r_op)
            OP_MOV: begin
                w_res = r_op_a;
                w_cy  = 1'b0;
            end
            OP_LDI: begin
                w_res = r_imm;
                w_cy  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_op             <= OP_ADD;
            r_rd             <= '0;
            r_imm            <= '0;
            r_op_a           <= '0;
            r_op_b           <= '0;
            r_cmd_ready      <= 1'b1;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_rf_mode        <= 1'b0;
            r_rf_write_addr  <= '0;
            r_rf_write_value <= '0;
            r_rf_read_addr1  <= '0;
            r_rf_read_addr2  <= '0;
            r_result         <= '0;
            r_carry          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op            <= bus.cmd_op;
                        r_rd            <= bus.cmd_rd;
                        r_imm           <= bus.cmd_imm;
                        r_rf_read_addr1 <= bus.cmd_rs1;
                        r_rf_read_addr2 <= bus.cmd_rs2;
                        r_cmd_ready     <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= S_READ;
                    end
                end
                S_READ: begin
                    r_op_a  <= w_rd_val1;
                    r_op_b  <= w_rd_val2;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result         <= w_res;
                    r_carry          <= w_cy;
                    r_rf_write_addr  <= r_rd;
                    r_rf_write_value <= w_res;
                    r_state          <= S_WSETUP;
                end
                S_WSETUP: begin
                    r_rf_mode <= w_wr_en;
                    r_state   <= S_WCOMMIT;
                end
                S_WCOMMIT: begin
                    r_rf_mode   <= 1'b0;
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = r_cmd_ready;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.rf_mode        = r_rf_mode;
    assign bus.rf_write_addr  = r_rf_write_addr;
    assign bus.rf_write_value = r_rf_write_value;
    assign bus.rf_read_addr1  = r_rf_read_addr1;
    assign bus.rf_read_addr2  = r_rf_read_addr2;
    assign bus.result         = r_result;
    assign bus.carry          = r_carry;
endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer: register-file environment, command-level reference model checked every cycle, directed literal checks.
module tb_rf_alu_sequencer;
`ifdef RFSEQ_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    rf_alu_sequencer_if bus();

    rf_alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file: combinational reads, write on the edge while rf_mode is high.
    logic [15:0] rf_mem [32] = '{default: 16'h0000};
    assign bus.rf_read_value1 = rf_mem[bus.rf_read_addr1];
    assign bus.rf_read_value2 = rf_mem[bus.rf_read_addr2];
    always @(posedge clk) if (bus.rf_mode) rf_mem[bus.rf_write_addr] <= bus.rf_write_value;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents and the one command in flight.
    logic [15:0] ref_rf [32] = '{default: 16'h0000};
    bit          pend = 0;
    int          pend_acc;
    logic [4:0]  pend_rd;
    logic [15:0] pend_val;
    logic        pend_c;
    bit          pend_wr;
    logic [15:0] last_val = 0;
    logic        last_c = 0;
    logic [4:0]  last_wa = 0;

    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] imm, output logic [15:0] res, output logic c);
        int s;
        case (op)
            2'd0: begin s = int'(a) + int'(b); c = (s >= 65536); res = s[15:0]; end
            2'd1: begin c = (a >= b); s = int'(a) - int'(b); if (s < 0) s += 65536; res = s[15:0]; end
            2'd2: begin res = a; c = 1'b0; end
            default: begin res = imm; c = 1'b0; end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; last_val = 0; last_c = 0; last_wa = 0;
                chk("rst_cmd_ready", bus.cmd_ready, 1);
                chk("rst_busy", bus.busy, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_rf_mode", bus.rf_mode, 0);
                chk("rst_write_addr", bus.rf_write_addr, 0);
                chk("rst_write_value", bus.rf_write_value, 0);
                chk("rst_read_addr1", bus.rf_read_addr1, 0);
                chk("rst_read_addr2", bus.rf_read_addr2, 0);
                chk("rst_result", bus.result, 0);
                chk("rst_carry", bus.carry, 0);
            end else begin
                bit e_done, e_mode, e_busy, late;
                e_done = pend && (cyc == pend_acc + 4);
                e_mode = pend && (cyc == pend_acc + 3) && pend_wr;
                e_busy = pend && (cyc < pend_acc + 4);
                late   = pend && (cyc >= pend_acc + 2);
                chk("done", bus.done, e_done);
                chk("rf_mode", bus.rf_mode, e_mode);
                chk("busy", bus.busy, e_busy);
                chk("cmd_ready", bus.cmd_ready, !e_busy);
                chk("result", bus.result, late ? pend_val : last_val);
                chk("carry", bus.carry, late ? pend_c : last_c);
                chk("write_addr", bus.rf_write_addr, late ? pend_rd : last_wa);
                chk("write_value", bus.rf_write_value, late ? pend_val : last_val);
                if (e_done) begin
                    if (pend_wr) ref_rf[pend_rd] = pend_val;
                    last_val = pend_val; last_c = pend_c; last_wa = pend_rd;
                    pend = 0;
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    logic [15:0] a, b;
                    a = (ZR && bus.cmd_rs1 == 0) ? 16'h0 : ref_rf[bus.cmd_rs1];
                    b = (ZR && bus.cmd_rs2 == 0) ? 16'h0 : ref_rf[bus.cmd_rs2];
                    model(bus.cmd_op, a, b, bus.cmd_imm, pend_val, pend_c);
                    pend_rd  = bus.cmd_rd;
                    pend_wr  = !(ZR && bus.cmd_rd == 0);
                    pend_acc = cyc + 1;
                    pend     = 1;
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [15:0] imm);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    endtask

    task automatic scramble();
        bus.cmd_valid = 1'b0;
        bus.cmd_op  = 2'($urandom);  bus.cmd_rd  = 5'($urandom);
        bus.cmd_rs1 = 5'($urandom);  bus.cmd_rs2 = 5'($urandom);
        bus.cmd_imm = 16'($urandom);
    endtask

    // Waits for cmd_ready at a negedge; returns the cycle index seen there.
    task automatic wait_accept(input string name, output int at);
        bit ok = 0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin ok = 1; at = cyc; break; end
        end
        chk({name, "_accept"}, ok, 1);
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm,
                           input logic [15:0] exp_val, input logic exp_c);
        int at, n;
        bit seen;
        @(posedge clk); #1;
        drive(op, rd, rs1, rs2, imm);
        wait_accept(name, at);
        @(posedge clk); #1;
        scramble();
        n = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.done) begin seen = 1; break; end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_done_latency"}, n, 5);
        chk({name, "_result"}, bus.result, exp_val);
        chk({name, "_carry"}, bus.carry, exp_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acc [4];
        int at;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_rd = 5'd0;
        bus.cmd_rs1 = 5'd0; bus.cmd_rs2 = 5'd0; bus.cmd_imm = 16'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        run_cmd("ldi_r1", 2'd3, 5'd1, 5'd0, 5'd0, 16'h1263, 16'h1263, 1'b0);
        run_cmd("ldi_r2", 2'd3, 5'd2, 5'd7, 5'd9, 16'h2432, 16'h2432, 1'b0);
        run_cmd("add_r3", 2'd0, 5'd3, 5'd1, 5'd2, 16'h0000, 16'h3695, 1'b0);
        run_cmd("ldi_r4", 2'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        run_cmd("ldi_r5", 2'd3, 5'd5, 5'd0, 5'd0, 16'h0001, 16'h0001, 1'b0);
        run_cmd("add_r6", 2'd0, 5'd6, 5'd4, 5'd5, 16'h0000, 16'h0000, 1'b1);
        run_cmd("sub_r7", 2'd1, 5'd7, 5'd1, 5'd2, 16'h0000, 16'hEE31, 1'b0);
        run_cmd("sub_r11", 2'd1, 5'd11, 5'd2, 5'd1, 16'h0000, 16'h11CF, 1'b1);

        // Four commands with cmd_valid held high throughout.
        @(posedge clk); #1;
        drive(2'd3, 5'd12, 5'd0, 5'd0, 16'h0101);
        for (int k = 0; k < 4; k++) begin
            wait_accept("queued", acc[k]);
            @(posedge clk); #1;
            case (k)
                0: drive(2'd3, 5'd13, 5'd0, 5'd0, 16'h0202);
                1: drive(2'd0, 5'd14, 5'd12, 5'd13, 16'h0000);
                2: drive(2'd1, 5'd15, 5'd14, 5'd12, 16'h0000);
                default: scramble();
            endcase
        end
        for (int k = 1; k < 4; k++) chk("queued_spacing", acc[k] - acc[k-1], 5);
        repeat (6) @(negedge clk);

        run_cmd("add_r1_self", 2'd0, 5'd1, 5'd1, 5'd1, 16'h0000, 16'h24C6, 1'b0);
        run_cmd("mov_r8", 2'd2, 5'd8, 5'd1, 5'd3, 16'h0000, 16'h24C6, 1'b0);

        // Reset lands in WSETUP of LDI r9: the write must never happen.
        @(posedge clk); #1;
        drive(2'd3, 5'd9, 5'd0, 5'd0, 16'hABCD);
        wait_accept("ldi_r9", at);
        @(posedge clk); #1;
        scramble();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("r9_unwritten", rf_mem[9], 16'h0000);
        run_cmd("ldi_r16_after_rst", 2'd3, 5'd16, 5'd0, 5'd0, 16'h7777, 16'h7777, 1'b0);

        run_cmd("ldi_r0", 2'd3, 5'd0, 5'd0, 5'd0, 16'h5555, 16'h5555, 1'b0);
        run_cmd("add_r10", 2'd0, 5'd10, 5'd0, 5'd1, 16'h0000,
                ZR ? 16'h24C6 : 16'h7A1B, 1'b0);
        repeat (3) @(negedge clk);

        chk("rf_r3", rf_mem[3], 16'h3695);
        chk("rf_r6", rf_mem[6], 16'h0000);
        chk("rf_r7", rf_mem[7], 16'hEE31);
        chk("rf_r11", rf_mem[11], 16'h11CF);
        chk("rf_r12", rf_mem[12], 16'h0101);
        chk("rf_r13", rf_mem[13], 16'h0202);
        chk("rf_r14", rf_mem[14], 16'h0303);
        chk("rf_r15", rf_mem[15], 16'h0202);
        chk("rf_r1", rf_mem[1], 16'h24C6);
        chk("rf_r8", rf_mem[8], 16'h24C6);
        chk("rf_r16", rf_mem[16], 16'h7777);
        chk("rf_r10", rf_mem[10], ZR ? 16'h24C6 : 16'h7A1B);
        chk("rf_r0", rf_mem[0], ZR ? 16'h0000 : 16'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Command-driven controller that sequences the 16-bit × 32-entry register file and an internal 16-bit adder/subtractor. It accepts one register-to-register command per valid/ready handshake, drives both register-file read ports, computes the result, and performs a two-phase write (setup, then mode pulse). It sits between the instruction source and the register file, and is the sole owner of the register-file mode, address and write-value inputs.

## Interface
- DATA_W, 16, data width of register file and operands
- ADDR_W, 5, register address width (32 entries)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  2  00 ADD, 01 SUB, 10 MOV (rd=rs1), 11 LDI (rd=imm)
- cmd_rd / cmd_rs1 / cmd_rs2  in  ADDR_W each  destination / source registers
- cmd_imm  in  DATA_W  immediate for LDI
- rf_mode  out  1  register-file mode (0 read, 1 write)
- rf_write_addr  out  ADDR_W  register-file write address
- rf_write_value  out  DATA_W  register-file write data
- rf_read_addr1, rf_read_addr2  out  ADDR_W  register-file read addresses
- rf_read_value1, rf_read_value2  in  DATA_W  register-file read data (combinational)
- result  out  DATA_W  last written value
- carry  out  1  carry / no-borrow of last ADD/SUB; 0 after MOV/LDI
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE → READ → EXEC → WSETUP → WCOMMIT → IDLE; unconditional after IDLE.
- IDLE: cmd_ready=1; cmd_valid&cmd_ready at an edge latches op, rd, rs1, rs2, imm and moves to READ.
- READ: rf_read_addr1=rs1, rf_read_addr2=rs2, rf_mode=0; operands registered from rf_read_value1/2 at end of cycle.
- EXEC: 17-bit compute. ADD: a+b. SUB: a+~b+1. carry=bit 16 (SUB: 1 = no borrow). MOV: a, carry=0. LDI: imm, carry=0. result and carry update at end of EXEC.
- WSETUP: rf_write_addr=rd, rf_write_value=result, rf_mode=0.
- WCOMMIT: same address and value held; rf_mode=1 for exactly this cycle.
- Return to IDLE: rf_mode=0 and done=1 for one cycle. The write address and value stay stable until the next WSETUP.
- All ops take identical latency. LDI and MOV still perform the READ cycle, and its results are ignored.
- rd may equal rs1/rs2. Operands are captured before the write, so the old value is used.
- cmd_valid outside IDLE is ignored, and command inputs need not be held.

## Timing
- Accept at edge N. READ is cycle N+1, EXEC N+2, WSETUP N+3, WCOMMIT N+4 (rf_mode=1), and done=1 in N+5.
- cmd_ready=1 in the done cycle, so back-to-back commands are accepted every 5 cycles.
- Write address and value are stable ≥1 full cycle before, during, and after the rf_mode pulse.
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, rf_mode=0, all rf addresses 0, rf_write_value=0, result=0, carry=0, operand and command registers 0.
- rst_n low at any time forces the reset values immediately, including rf_mode=0 mid-WCOMMIT. The in-flight command is discarded, with no done pulse and no further write.

## Configuration
- RFSEQ_ZERO_REG_EN defined:
  - register 0 reads as 0: an operand whose address is 0 is forced to 0 at READ capture.
  - rd=0 commands run full timing and pulse done, but rf_mode stays 0 in WCOMMIT.
  - result/carry still update.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset, then LDI r1=0x1263, LDI r2=0x2432, ADD r3=r1+r2 → r3=0x3695, carry=0, done exactly 5 cycles after each accept, rf_mode high exactly one cycle per command.
- LDI r4=0xFFFF, LDI r5=0x0001, ADD r6=r4+r5 → r6=0x0000, carry=1; SUB r7=r1-r2 → 0xEE31, carry=0; SUB r2-r1 → 0x11CF, carry=1.
- cmd_valid held high with 4 queued commands → accepts at edges N, N+5, N+10, N+15; cmd_ready low in between; no command dropped or duplicated.
- ADD r1=r1+r1 with r1=0x1263 → r1=0x24C6 (old value used); MOV r8=r1 → r8=0x24C6, carry=0.
- rst_n low during WSETUP of LDI r9=0xABCD → rf_mode never 1, r9 unchanged, all outputs at reset values, next command completes normally.
- With RFSEQ_ZERO_REG_EN: LDI r0=0x5555 → done pulses, rf_mode stays 0; ADD r10=r0+r1 → r10=r1. Without the macro: r0 reads back 0x5555.
